fixed_to_float32_pipe: RTL and testbench

Pipelined, parametrised converter from a fixed-point number (configurable integer/fraction widths, signed or unsigned) to IEEE-754 binary32, with round-to-nearest-even, an inexact flag and valid/ready handshakes on both sides. It sits between the fixed-point exponential datapath and any float32 consumer. It replaces the combinational 3.23 converter, which truncates and is limited to a single format.

---
 rtl/fixed_to_float32_pipe.sv | 123 ++++++++++++
 tb/tb_fixed_to_float32_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float32_pipe.sv
// Three-stage fixed-point to IEEE-754 binary32 converter with round-to-nearest-even,
// an inexact flag and a stall-all valid/ready pipeline.
module fixed_to_float32_pipe #(
    parameter int unsigned NUM_INT  = 3,
    parameter int unsigned NUM_FRAC = 23,
    parameter bit          SIGNED   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_INT+NUM_FRAC-1:0] in_fixed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_float32,
    output logic                        out_inexact
);

    localparam int unsigned W       = NUM_INT + NUM_FRAC;
    // Working register is at least 26 bits so hidden+23+guard+sticky always exist.
    localparam int unsigned L       = (W + 1 > 26) ? W + 1 : 26;
    localparam int unsigned PW      = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SW      = $clog2(L) + 1;
    localparam int unsigned EXP_OFS = 127 - NUM_FRAC;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: sign and magnitude
    logic         s1_valid;
    logic         s1_sign;
    logic [W-1:0] s1_mag;
    logic         sign_c;
    logic [W-1:0] mag_c;

    always_comb begin
        sign_c = 1'b0;
        mag_c  = in_fixed;
        if (SIGNED) begin
            sign_c = in_fixed[W-1];
            if (sign_c) mag_c = ~in_fixed + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= sign_c;
            s1_mag   <= mag_c;
        end
    end

    // Stage 2: leading-one detection and left normalisation
    logic [PW-1:0] lod_c;
    logic [SW-1:0] shift_c;
    logic [L-1:0]  norm_c;
    logic [7:0]    exp_c;

    always_comb begin
        lod_c = '0;
        for (int i = 0; i < W; i++) begin
            if (s1_mag[i]) lod_c = PW'(i);
        end
        shift_c = SW'(L - 1) - SW'(lod_c);
        norm_c  = L'(s1_mag) << shift_c;
        exp_c   = 8'(32'(lod_c) + EXP_OFS);
    end

    logic         s2_valid;
    logic         s2_sign;
    logic [7:0]   s2_exp;
    logic [L-1:0] s2_norm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_norm  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_exp   <= exp_c;
            s2_norm  <= norm_c;
        end
    end

    // Stage 3: round to nearest even and pack; a zero magnitude leaves the top bit clear
    logic        nz_c;
    logic        guard_c;
    logic        sticky_c;
    logic        rnd_c;
    logic        carry_c;
    logic [22:0] frac_c;
    logic [7:0]  exp_r_c;

    always_comb begin
        nz_c              = s2_norm[L-1];
        guard_c           = s2_norm[L-25];
        sticky_c          = |s2_norm[L-26:0];
        rnd_c             = guard_c & (sticky_c | s2_norm[L-24]);
        {carry_c, frac_c} = {1'b0, s2_norm[L-2 -: 23]} + 24'(rnd_c);
        exp_r_c           = s2_exp + 8'(carry_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_float32 <= '0;
            out_inexact <= 1'b0;
        end else if (en) begin
            out_valid   <= s2_valid;
            out_float32 <= nz_c ? {s2_sign, exp_r_c, frac_c} : 32'h0000_0000;
            out_inexact <= nz_c & (guard_c | sticky_c);
        end
    end

endmodule

// File: tb/tb_fixed_to_float32_pipe.sv
// Bench for fixed_to_float32_pipe: directed, streaming, backpressure and mid-stream reset
// scenarios with a queue-based scoreboard and an independent rounding model.
module tb_fixed_to_float32_pipe;

    localparam int unsigned NI = 3;
    localparam int unsigned NF = 23;
    localparam int unsigned W  = NI + NF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_fixed;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_float32;
    logic         out_inexact;

    logic         u_in_valid;
    logic         u_in_ready;
    logic [W-1:0] u_in_fixed;
    logic         u_out_valid;
    logic         u_out_ready;
    logic [31:0]  u_out_float32;
    logic         u_out_inexact;

    always #5 clk = ~clk;

    fixed_to_float32_pipe #(.NUM_INT(NI), .NUM_FRAC(NF), .SIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fixed(in_fixed), .out_valid(out_valid), .out_ready(out_ready),
        .out_float32(out_float32), .out_inexact(out_inexact)
    );

    fixed_to_float32_pipe #(.NUM_INT(NI), .NUM_FRAC(NF), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .in_fixed(u_in_fixed), .out_valid(u_out_valid), .out_ready(u_out_ready),
        .out_float32(u_out_float32), .out_inexact(u_out_inexact)
    );

    typedef struct {
        logic [31:0] f;
        logic        inex;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_lat = 1'b1;
    bit          bp_mode = 1'b0;
    bit          held_v = 1'b0;
    logic [31:0] held_f;
    logic        held_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: integer rounding of the magnitude, returns {inexact, float32}
    function automatic logic [32:0] model(input logic [W-1:0] x);
        logic [63:0] m, q, rem, half;
        logic        sign, inex;
        int          p, drop, e;
        sign = x[W-1];
        m    = 64'(x);
        if (sign) m = (64'd1 << W) - m;
        if (m == 64'd0) return 33'd0;
        p = 63;
        while (m[p] == 1'b0) p--;
        inex = 1'b0;
        if (p > 23) begin
            drop = p - 23;
            q    = m >> drop;
            rem  = m & ((64'd1 << drop) - 64'd1);
            half = 64'd1 << (drop - 1);
            inex = (rem != 64'd0);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q[24]) begin
                q = q >> 1;
                p++;
            end
        end else begin
            q = m << (23 - p);
        end
        e = p - int'(NF) + 127;
        return {inex, sign, e[7:0], q[22:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: pops the scoreboard on every output transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_float", out_float32, held_f);
                check("stall_inexact", 32'(out_inexact), 32'(held_i));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("float", out_float32, e.f);
                    check("inexact", 32'(out_inexact), 32'(e.inex));
                    if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
                end
            end
            held_v = out_valid && !out_ready;
            held_f = out_float32;
            held_i = out_inexact;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [W-1:0] x, input logic [31:0] ef, input logic ei, input bit push);
        int   n;
        bit   acc;
        exp_t e;
        in_valid = 1'b1;
        in_fixed = x;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && push) begin
                e.f    = ef;
                e.inex = ei;
                e.cyc  = cyc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic u_convert(input logic [W-1:0] x, input logic [31:0] ef, input logic ei);
        int n;
        u_in_valid = 1'b1;
        u_in_fixed = x;
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        n = 0;
        while (!u_out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("u_valid", 32'(u_out_valid), 32'd1);
        check("u_latency", 32'(n), 32'd2);
        check("u_float", u_out_float32, ef);
        check("u_inexact", 32'(u_out_inexact), 32'(ei));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] x;
        logic [32:0]  r;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_fixed    = '0;
        u_in_valid  = 1'b0;
        u_in_fixed  = '0;
        u_out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_float", out_float32, 32'h0000_0000);
        check("rst_inexact", 32'(out_inexact), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Eight directed samples back to back: exact values, zero and rounding cases
        send(26'h0800000, 32'h3F80_0000, 1'b0, 1'b1);
        send(26'h3800000, 32'hBF80_0000, 1'b0, 1'b1);
        send(26'h2000000, 32'hC080_0000, 1'b0, 1'b1);
        send(26'h0000001, 32'h3400_0000, 1'b0, 1'b1);
        send(26'h0000000, 32'h0000_0000, 1'b0, 1'b1);
        send(26'h1FFFFFF, 32'h4080_0000, 1'b1, 1'b1);
        send(26'h1000001, 32'h4000_0000, 1'b1, 1'b1);
        send(26'h1000003, 32'h4000_0002, 1'b1, 1'b1);
        drain();

        u_convert(26'h3FFFFFF, 32'h4100_0000, 1'b1);
        u_convert(26'h2000000, 32'h4080_0000, 1'b0);

        // Random samples under random backpressure
        chk_lat = 1'b0;
        bp_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            x = W'($urandom());
            if (i % 25 == 0) x = 26'h2000000;
            if (i % 25 == 1) x = 26'h0000000;
            r = model(x);
            send(x, r[31:0], r[32], 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_mode = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        drain();

        // Reset with three samples in flight; none of them may emerge
        chk_lat = 1'b1;
        send(26'h0C00000, 32'h0, 1'b0, 1'b0);
        send(26'h1400000, 32'h0, 1'b0, 1'b0);
        send(26'h3F00000, 32'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_float", out_float32, 32'h0000_0000);
        check("midrst_inexact", 32'(out_inexact), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        send(26'h0800000, 32'h3F80_0000, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
